// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU issue controller.
package alu_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_core.sv
// Combinational ALU: result and illegal-opcode flag from latched operands.
module alu_core
    import alu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            err_o
);

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Round-robin issue of one ALU op at a time from two requesters, with a
// fixed execute latency and a held response until handshake.
//
// state   | meaning
// IDLE    | waiting for a request; req_ready grants one requester
// EXEC    | counting down the execute latency on latched operands
// RESP    | response presented, held until rsp_ready
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*OP_W-1:0] req_op,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_result,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            prio_q, prio_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            id_q, id_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            err_q, err_d;

    logic [1:0]      grant;
    logic            accept;
    logic            grant_id;
    logic [XLEN-1:0] alu_result;
    logic            alu_err;

    alu_core u_alu_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    // prio_q names the requester that wins a tie; rst_n gating keeps
    // req_ready low while reset is held even though state is already IDLE.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state_q == ST_IDLE) begin
            if (req_valid == 2'b11) begin
                grant = prio_q ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign grant_id  = grant[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = grant_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
                    a_d     = grant_id ? req_a[2*XLEN-1:XLEN]  : req_a[XLEN-1:0];
                    b_d     = grant_id ? req_b[2*XLEN-1:XLEN]  : req_b[XLEN-1:0];
                    id_d    = grant_id;
                    prio_d  = ~grant_id;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    result_d = alu_result;
                    err_d    = alu_err;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prio_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prio_q   <= prio_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_valid & id_q;
    assign rsp_result = rsp_valid ? result_q : '0;
    assign rsp_err    = rsp_valid & err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter EXEC_CYCLES, default 2, ALU execute latency in cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester request accept.
REQ-006 req_op  input  8  opcodes, [3:0] requester 0, [7:4] requester 1.
REQ-007 req_a  input  64  operand A, [31:0] requester 0, [63:32] requester 1.
REQ-008 req_b  input  64  operand B, same packing as req_a.
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_ready  input  1  response accept.
REQ-011 rsp_id  output  1  requester index owning the response.
REQ-012 rsp_result  output  32  ALU result.
REQ-013 rsp_err  output  1  opcode illegal.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-016 IDLE: req_ready is one-hot to the granted requester when any req_valid is high, otherwise 2'b00; req_ready is 2'b00 in EXEC and RESP.
REQ-017 Arbitration is round-robin: with one requester valid it is granted; with both valid, grant goes to the requester not granted last; after reset requester 0 has priority.
REQ-018 req_ready is a combinational function of state, req_valid and the priority pointer only.
REQ-019 Accept = req_valid[i] && req_ready[i] at a rising edge; on accept, latch op, a, b and id, update the priority pointer, load the cycle counter with EXEC_CYCLES-1, and go to EXEC.
REQ-020 Latched op, a, b and id stay constant from accept until the response handshake; later changes on req_* have no effect.
REQ-021 EXEC: decrement the counter each cycle; at the edge where the counter is 0, register result and err and go to RESP.
REQ-022 rsp_valid is high exactly in RESP; it is first high EXEC_CYCLES cycles after the accept edge.
REQ-023 RESP: rsp_valid, rsp_id, rsp_result and rsp_err are held stable until rsp_valid && rsp_ready; on that edge go to IDLE.
REQ-024 A new request can be accepted no earlier than the cycle after the response handshake; peak throughput is one op per EXEC_CYCLES+2 cycles.
REQ-025 Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR; arithmetic is modulo 2^32 and carry/borrow are discarded.
REQ-026 Opcodes 5..15: rsp_err=1 and rsp_result=32'h0, with the same latency and handshake as legal opcodes.
REQ-027 rsp_id, rsp_result and rsp_err read 0 whenever rsp_valid is low.

Reset
REQ-028 rst_n low immediately forces state IDLE, counter 0, priority pointer to requester 0, and all latched operands and results to 0.
REQ-029 While rst_n is low all outputs are 0 (req_ready=2'b00, rsp_valid=0, busy=0).
REQ-030 An operation in flight when reset asserts is dropped; no response for it ever appears.
REQ-031 After rst_n deasserts, the first request may be accepted at the first rising edge.

Structure
REQ-032 Shared package alu_ctrl_pkg holds the opcode enum (ADD..XOR), the FSM state enum, XLEN=32 and the opcode width of 4.
REQ-033 Result computation is a combinational sub-module alu_core (op, a, b -> result, err), instantiated once on the latched operands.

Verification
REQ-034 Req0 ADD a=32'hFFFF_FFFF b=1, rsp_ready=1 -> rsp_result=0, rsp_err=0, rsp_id=0, rsp_valid first high 2 cycles after accept (EXEC_CYCLES=2).
REQ-035 Both valid at once: req0 SUB a=5 b=7, req1 XOR a=32'hF0F0 b=32'hFF00 -> req0 served first with 32'hFFFF_FFFE, then req1 with 32'h0FF0; the next simultaneous request pair grants req0.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable; req_ready=2'b00 and busy=1 throughout.
REQ-037 Req1 opcode 4'hA, a=3, b=4 -> rsp_err=1, rsp_result=0, rsp_id=1, normal latency.
REQ-038 Accept req0 AND a=32'hFF00_FF00 b=32'h0FF0_0FF0, then change req_a to 0 during EXEC -> rsp_result=32'h0F00_0F00.
REQ-039 Assert rst_n=0 during EXEC -> all outputs 0 in the same cycle; after release no response for the dropped op, and the next request is accepted with requester 0 at priority.
